reg_bank_rd: RTL and testbench
==============================

REG_BANK_RD -- requirements
Module: reg_bank_rd

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The module SHALL have parameter SP_RESET, default 32'd227, meaning the reset value of register 29 (stack pointer).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 Port RegWrite  input  1  write strobe for the current cycle.
REQ-006 Port WriteReg  input  5  destination register number (driven by the destination-select mux, 5 bits used).
REQ-007 Port WriteData  input  DATA_W  data to write.
REQ-008 Port ReadReg1, ReadReg2  input  5 each  source register numbers.
REQ-009 Port ReadData1, ReadData2  output  DATA_W each  registered read data.
REQ-010 Port WriteCount  output  8  number of committed writes, for debug.

Function
REQ-011 Storage SHALL be 32 registers of DATA_W bits, indices 0..31.
REQ-012 On a rising clk with RegWrite=1 and WriteReg!=0, register WriteReg SHALL take WriteData.
REQ-013 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-014 Reads SHALL have 1-cycle latency: ReadDataN at edge k+1 reflects ReadRegN sampled at edge k and the register contents before edge k's write.
REQ-015 Both read ports SHALL operate independently; both may address the same register in the same cycle.
REQ-016 WriteCount SHALL increment by 1 on each committed write (RegWrite=1, WriteReg!=0), wrapping 255 -> 0; discarded writes SHALL NOT count.
REQ-017 RegWrite=0 SHALL leave all registers and WriteCount unchanged.
REQ-018 X on WriteReg while RegWrite=0 SHALL NOT corrupt any register.

Reset
REQ-019 While reset=0, register 29 SHALL equal SP_RESET, all other registers SHALL equal 0, ReadData1/ReadData2 SHALL equal 0, and WriteCount SHALL equal 0, independent of clk.
REQ-020 Reset deassertion SHALL take effect at the next rising clk; a write presented on the first rising clk after deassertion SHALL commit.
REQ-021 Reset asserted mid-cycle SHALL override any write in progress.

Configuration
REQ-022 Macro REG_BANK_BYPASS_EN SHALL select read-during-write forwarding.
REQ-023 With REG_BANK_BYPASS_EN defined: when at edge k a committed write targets ReadRegN, ReadDataN at edge k+1 SHALL equal WriteData (new value).
REQ-024 Without REG_BANK_BYPASS_EN: in that case ReadDataN SHALL equal the old register value; the new value is visible from the following read.
REQ-025 Register 0 SHALL never be forwarded in either configuration.

Structure
REQ-026 A shared package SHALL hold REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31, REG_ADDR_W=5 and the SP_RESET default; the destination-select mux SHALL use the same constants.
REQ-027 One sub-module reg_bank_rd_port (one registered read port with optional bypass) SHALL be instantiated twice; the storage array SHALL be in the top.

Verification
REQ-028 Reset pulse low, then read regs 29 and 31 -> ReadData1=227, ReadData2=0, WriteCount=0.
REQ-029 Write 0xDEADBEEF to reg 0, then read reg 0 -> ReadData1=0, WriteCount unchanged.
REQ-030 Write 0x12345678 to reg 31, read reg 31 next cycle on both ports -> both 0x12345678, WriteCount=1.
REQ-031 Same-edge write 0xA5A5A5A5 to reg 8 with ReadReg1=8 (old value 0) -> ReadData1=0xA5A5A5A5 with REG_BANK_BYPASS_EN, 0 without.
REQ-032 256 committed writes after reset -> WriteCount wraps to 0; 257th -> 1.
REQ-033 Assert reset mid-cycle during a write of 0x55 to reg 29 -> reg 29 reads 227 after release.

Source files
------------

// File: rtl/reg_bank_rd_pkg.sv
// Shared constants for the register bank and the destination-select mux feeding WriteReg.
package reg_bank_rd_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'd227;

  typedef enum logic [1:0] {DstRt, DstRd, DstRa} dst_sel_e;

  // Destination-select mux: rt for immediates, rd for R-type, ra for link instructions.
  function automatic logic [REG_ADDR_W-1:0] dst_mux(input dst_sel_e sel,
                                                    input logic [REG_ADDR_W-1:0] rt,
                                                    input logic [REG_ADDR_W-1:0] rd);
    logic [REG_ADDR_W-1:0] dst;
    case (sel)
      DstRt:   dst = rt;
      DstRd:   dst = rd;
      DstRa:   dst = REG_RA;
      default: dst = REG_ZERO;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One registered read port of the register bank.
// REG_BANK_BYPASS_EN forwards a same-edge committed write to the read result.
module reg_bank_rd_port
  import reg_bank_rd_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_i,
  input  logic [REG_ADDR_W-1:0]              rd_addr_i,
  input  logic                               wr_en_i,
  input  logic [REG_ADDR_W-1:0]              wr_addr_i,
  input  logic [DATA_W-1:0]                  wr_data_i,
  output logic [DATA_W-1:0]                  rd_data_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    rd_data_d = regs_i[rd_addr_i];
    // Register 0 is never forwarded even if a stray write strobe targets it.
    if (wr_en_i && (wr_addr_i == rd_addr_i) && (wr_addr_i != REG_ZERO)) begin
      rd_data_d = wr_data_i;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

  always_comb begin
    rd_data_d = regs_i[rd_addr_i];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_bank_rd.sv
// 32-entry register bank with two registered read ports and a write counter.
// Define REG_BANK_BYPASS_EN to forward same-edge writes to the read ports.
module reg_bank_rd
  import reg_bank_rd_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    SP_RESET = DATA_W'(SP_RESET_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [7:0]            WriteCount
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;
  logic [7:0]                      wr_count_d, wr_count_q;
  logic                            wr_commit;

  // RegWrite gates first so an unknown WriteReg cannot enable a write.
  assign wr_commit = RegWrite && (WriteReg != REG_ZERO);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      regs_d[WriteReg] = WriteData;
      wr_count_d       = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign WriteCount = wr_count_q;

  reg_bank_rd_port #(
    .DATA_W (DATA_W)
  ) u_port1 (
    .clk_i     (clk),
    .rst_ni    (reset),
    .regs_i    (regs_q),
    .rd_addr_i (ReadReg1),
    .wr_en_i   (wr_commit),
    .wr_addr_i (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData1)
  );

  reg_bank_rd_port #(
    .DATA_W (DATA_W)
  ) u_port2 (
    .clk_i     (clk),
    .rst_ni    (reset),
    .regs_i    (regs_q),
    .rd_addr_i (ReadReg2),
    .wr_en_i   (wr_commit),
    .wr_addr_i (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData2)
  );

endmodule

// File: tb/tb_reg_bank_rd.sv
// Scoreboard bench for reg_bank_rd: driver pushes expected responses, monitor pops and compares.
module tb_reg_bank_rd;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [7:0]  WriteCount;

  reg_bank_rd dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .WriteCount (WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [7:0]  wc;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mem[32];
  int          wr_total;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[29]  = 32'd227;
    wr_total = 0;
  endfunction

  // Value a read port presents one edge after sampling addr alongside the given write.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : mem[a];
`ifdef REG_BANK_BYPASS_EN
    if (we) begin
      if (wr == a && a != 5'd0) v = wd;
    end
`endif
    return v;
  endfunction

  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    RegWrite  = we;
    WriteReg  = wr;
    WriteData = wd;
    ReadReg1  = a1;
    ReadReg2  = a2;
    e.rd1 = model_read(a1, we, wr, wd);
    e.rd2 = model_read(a2, we, wr, wd);
    if (we) begin
      if (wr != 5'd0) begin
        mem[wr]  = wd;
        wr_total = wr_total + 1;
      end
    end
    e.wc = 8'(wr_total % 256);
    expq.push_back(e);
    @(posedge clk);
  endtask

  // Assert just after a rising edge; release in the high phase so the next edge is the first.
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_rd1", ReadData1, 32'd0);
    chk("reset_rd2", ReadData2, 32'd0);
    chk("reset_wc", {24'd0, WriteCount}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("ReadData1", ReadData1, e.rd1);
        chk("ReadData2", ReadData2, e.rd2);
        chk("WriteCount", {24'd0, WriteCount}, {24'd0, e.wc});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we;
    logic [4:0]  wr, a1, a2;
    logic [31:0] wd;

    reset     = 1'b1;
    RegWrite  = 1'b0;
    WriteReg  = 5'd0;
    WriteData = 32'd0;
    ReadReg1  = 5'd0;
    ReadReg2  = 5'd0;
    model_reset();

    do_reset();
    // Reset values of SP and RA; then write to reg 0 is dropped.
    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd31);
    cycle(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b1, 5'd31, 32'h12345678, 5'd1, 5'd2);
    cycle(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    // Same-edge write and read of reg 8, then the follow-up read.
    cycle(1'b1, 5'd8, 32'hA5A5A5A5, 5'd8, 5'd29);
    cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
    // Unknown WriteReg with RegWrite low must not disturb anything.
    cycle(1'b0, 5'bxxxxx, 32'hFFFFFFFF, 5'd8, 5'd31);
    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd1);

    // Reset deasserted: the very first edge carries a committed write.
    do_reset();
    cycle(1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd29);
    cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);

    // Counter wrap: 256 committed writes return to 0, the 257th gives 1.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 5'(1 + (i % 31)), $urandom, 5'($urandom_range(0, 31)), 5'(1 + (i % 31)));
    end

    // Reset landing in the middle of a write to SP overrides it.
    @(negedge clk);
    RegWrite  = 1'b1;
    WriteReg  = 5'd29;
    WriteData = 32'h55;
    #2 reset = 1'b0;
    #1;
    chk("midreset_rd1", ReadData1, 32'd0);
    chk("midreset_wc", {24'd0, WriteCount}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd31);

    // Randomised traffic, biased so reads often hit the write target.
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 1) == 1);
      wr = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      cycle(we, wr, wd, a1, a2);
    end

    @(negedge clk);
    RegWrite = 1'b0;
    #2;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
